axil_csr_slave: RTL and testbench

AXIL_CSR_SLAVE -- requirements
Module: axil_csr_slave

---
 rtl/axil_csr_slave.sv | 155 +++++++++++++++
 tb/tb_axil_csr_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axil_csr_slave.sv
// rtl/axil_csr_slave.sv - AXI-Lite CSR slave: CTRL start pulse, STATUS readback, byte-enabled cfg registers
// Write address and data are latched independently and committed together one cycle later.
module axil_csr_slave #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ADDR_WIDTH-1:0]              S_AXI_AWADDR,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]              S_AXI_ARADDR,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic                               start_o,
  input  logic                               busy_i,
  input  logic                               done_i,
  output logic [(NUM_REGS-2)*AXI_DATA_WIDTH-1:0] cfg_o
);

  localparam int DW = AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = $clog2(NUM_REGS);
  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                       active_q;
  logic                       aw_full_q, w_full_q;
  logic [WW-1:0]              awaddr_q;
  logic [DW-1:0]              wdata_q;
  logic [SW-1:0]              wstrb_q;
  logic                       bvalid_q;
  logic [1:0]                 bresp_q;
  logic                       rvalid_q;
  logic [1:0]                 rresp_q;
  logic [DW-1:0]              rdata_q;
  logic                       start_q;
  logic [(NUM_REGS-2)*DW-1:0] cfg_q, cfg_d;

  logic          aw_hs, w_hs, ar_hs, commit;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          wr_valid, wr_ok, rd_valid;
  logic [WW-1:0] rd_word;
  logic [DW-1:0] rd_data_d;
  logic          unused_addr_lsbs;

  // Readiness is gated by a registered out-of-reset flag so READY never depends on an input.
  assign S_AXI_AWREADY = active_q && !aw_full_q && !bvalid_q;
  assign S_AXI_WREADY  = active_q && !w_full_q && !bvalid_q;
  assign S_AXI_ARREADY = active_q && !rvalid_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = aw_full_q && w_full_q;

  assign wr_idx   = awaddr_q[IW-1:0];
  assign wr_valid = awaddr_q < WW'(NUM_REGS);
  assign wr_ok    = wr_valid && (wr_idx != IW'(1));

  assign rd_word  = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign rd_idx   = rd_word[IW-1:0];
  assign rd_valid = rd_word < WW'(NUM_REGS);

  assign unused_addr_lsbs = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    rd_data_d = '0;
    if (rd_valid) begin
      if (rd_idx == IW'(1)) rd_data_d = {{(DW-2){1'b0}}, done_i, busy_i};
      for (int r = 2; r < NUM_REGS; r++) begin
        if (rd_idx == IW'(r)) rd_data_d = cfg_q[(r-2)*DW +: DW];
      end
    end
  end

  always_comb begin
    cfg_d = cfg_q;
    if (commit && wr_ok) begin
      for (int r = 2; r < NUM_REGS; r++) begin
        for (int b = 0; b < SW; b++) begin
          if (wr_idx == IW'(r) && wstrb_q[b]) cfg_d[(r-2)*DW + 8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      start_q   <= 1'b0;
      cfg_q     <= '0;
    end else begin
      active_q <= 1'b1;
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        awaddr_q  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      start_q <= commit && wr_valid && (wr_idx == '0) && wstrb_q[0] && wdata_q[0];
      cfg_q   <= cfg_d;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data_d;
        rresp_q  <= rd_valid ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;
  assign start_o      = start_q;
  assign cfg_o        = cfg_q;

endmodule

// File: tb/tb_axil_csr_slave.sv
// tb/tb_axil_csr_slave.sv - directed self-checking bench for axil_csr_slave
module tb_axil_csr_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  awaddr, wdata, araddr;
  logic [3:0]   wstrb;
  logic         awvalid, wvalid, bready, arvalid, rready, busy, done;
  logic         awready, wready, bvalid, arready, rvalid, start;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [191:0] cfg;
  logic [1:0]   resp;
  logic [31:0]  data;
  int           checks = 0;
  int           failures = 0;
  int           start_cnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (start) start_cnt++;

  axil_csr_slave dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .start_o(start), .busy_i(busy), .done_i(done), .cfg_o(cfg)
  );

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
    int n;
    logic aw_hs, w_hs;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check_eq("wr_bvalid", bvalid, 1);
    r = bresp;
    tick();
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    logic hs;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      hs = arready;
      tick();
      if (hs) arvalid = 1'b0;
      n++;
    end
    while (!rvalid && n < 40) begin tick(); n++; end
    check_eq("rd_rvalid", rvalid, 1);
    d = rdata;
    r = rresp;
    tick();
    rready = 1'b0; arvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    busy = 1'b0; done = 1'b0;
    repeat (3) tick();
    check_eq("rst_ready", {awready, wready, arready}, 3'b000);
    check_eq("rst_valid", {bvalid, rvalid, start}, 3'b000);
    check_eq("rst_data", {bresp, rresp, rdata}, 36'h0);
    check_eq("rst_cfg", cfg, 192'h0);
    rst_n = 1'b1;
    tick();
    check_eq("rel_ready", {awready, wready, arready}, 3'b111);

    // Same-cycle AW/W, read of the target during the commit cycle, then stalled responses.
    awaddr = 32'h08; wdata = 32'hA5A5_1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("b_early", bvalid, 0);
    araddr = 32'h08; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check_eq("b_n2", {bvalid, bresp}, 3'b100);
    check_eq("cfg_reg2", cfg[31:0], 32'hA5A5_1234);
    check_eq("rd_precommit", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'h0});
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold", {bvalid, rvalid, awready, wready, arready, bresp, rdata},
               {1'b1, 1'b1, 3'b000, 2'b00, 32'h0});
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check_eq("release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
    check_eq("no_start", start_cnt, 0);

    // W first, AW three cycles later, partial strobes.
    wdata = 32'hFFFF_FFFF; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check_eq("w_full", wready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("w_wait", {bvalid, cfg[63:32]}, 33'h0);
    end
    awaddr = 32'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check_eq("aw_late_b0", bvalid, 0);
    tick();
    check_eq("aw_late_b1", {bvalid, bresp}, 3'b100);
    check_eq("cfg_reg3", cfg[63:32], 32'h0000_FFFF);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // CTRL start pulse and STATUS readback.
    axi_write(32'h00, 32'h1, 4'hF, resp);
    check_eq("ctrl_resp", resp, 2'b00);
    check_eq("start_once", start_cnt, 1);
    axi_read(32'h00, data, resp);
    check_eq("ctrl_read", {resp, data}, 34'h0);
    busy = 1'b1; done = 1'b0;
    axi_read(32'h04, data, resp);
    check_eq("status_busy", {resp, data}, {2'b00, 32'h1});
    busy = 1'b0; done = 1'b1;
    axi_read(32'h04, data, resp);
    check_eq("status_done", {resp, data}, {2'b00, 32'h2});
    check_eq("start_still1", start_cnt, 1);

    // Error responses and address decode boundaries.
    axi_read(32'h20, data, resp);
    check_eq("rd_oor", {resp, data}, {2'b10, 32'h0});
    axi_write(32'h04, 32'hFFFF_FFFF, 4'hF, resp);
    check_eq("wr_status", resp, 2'b10);
    axi_write(32'h40, 32'h1, 4'hF, resp);
    check_eq("wr_oor", resp, 2'b10);
    check_eq("oor_nostart", start_cnt, 1);
    check_eq("cfg_after_err", cfg, {128'h0, 32'h0000_FFFF, 32'hA5A5_1234});
    axi_write(32'h13, 32'h1122_3344, 4'h5, resp);
    check_eq("wr_lsb_ign", resp, 2'b00);
    axi_read(32'h12, data, resp);
    check_eq("rd_reg4", {resp, data}, {2'b00, 32'h0022_0044});
    axi_read(32'h1C, data, resp);
    check_eq("rd_reg7", {resp, data}, {2'b00, 32'h0});
    check_eq("cfg_all", cfg, {96'h0, 32'h0022_0044, 32'h0000_FFFF, 32'hA5A5_1234});

    // Reset with a latched AW and a pending R.
    awaddr = 32'h14; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check_eq("aw_only", {awready, wready}, 2'b01);
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    check_eq("r_pending", rvalid, 1);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst", {awready, wready, arready, bvalid, rvalid, start}, 6'b0);
    check_eq("mid_rst_cfg", cfg, 192'h0);
    rst_n = 1'b1;
    tick();
    check_eq("mid_rel_ready", {awready, wready, arready, rvalid}, 4'b1110);
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("aw_discarded", bvalid, 0);
    end
    awaddr = 32'h18; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    check_eq("post_rst_b", {bvalid, bresp}, 3'b100);
    check_eq("post_rst_cfg", cfg, {32'h0, 32'h77, 128'h0});
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_write(32'h1C, 32'hDEAD_BEEF, 4'hF, resp);
    check_eq("fresh_resp", resp, 2'b00);
    check_eq("fresh_cfg", cfg, {32'hDEAD_BEEF, 32'h77, 128'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
